// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch unit: accepts a PC from WBU, fetches one word over AXI4-Lite read, hands it to IDU.
// Optional feature macro IFU_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module ysyx_23060221_ifu #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] FAULT_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              WBU_valid,
  output logic              IFU_ready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  output logic              IFU_valid,
  input  logic              IDU_ready
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_OUT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst;
  logic              r_fault;
  logic              w_pc_aligned;
  logic              w_resp_err;

  assign w_pc_aligned = (pc[1:0] == 2'b00);
  assign w_resp_err   = (rresp != 2'b00);

  // Every output is a pure decode of state/registers, so no input reaches an output combinationally.
  assign IFU_ready  = (r_state == S_IDLE);
  assign arvalid    = (r_state == S_AR);
  assign rready     = (r_state == S_R);
  assign IFU_valid  = (r_state == S_OUT);
  assign araddr     = r_pc;
  assign inst_pc    = r_pc;
  assign inst       = r_inst;
  assign inst_fault = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_inst  <= FAULT_INST;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (WBU_valid) begin
            r_pc <= pc;
            if (w_pc_aligned) begin
              r_state <= S_AR;
            end else begin
              // Misaligned PC never touches the bus; report it straight to IDU as a fault.
              r_state <= S_OUT;
              r_inst  <= FAULT_INST;
              r_fault <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (arready) r_state <= S_R;
        end
        S_R: begin
          if (rvalid) begin
            r_inst  <= w_resp_err ? FAULT_INST : rdata;
            r_fault <= w_resp_err;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (IDU_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (r_state == S_OUT && IDU_ready)        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (r_state == S_AR || r_state == S_R)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
